// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I types for the decode/execute slice: opcodes, control packet,
// immediate bundle, bubble constant and the immediate builder.
package id_ex_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned OPCODE_W  = 7;

  typedef enum logic [OPCODE_W-1:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode_t;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Opcode is kept as raw bits so the all-zero bubble packet is representable.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [3:0]          aluop;
    logic [2:0]          cmpop;
    logic                alu_m1_sel;   // 1: PC, 0: rs1
    logic                alu_m2_sel;   // 1: immediate, 0: rs2
    logic                branch;
    logic                jump;
    logic                load_regfile;
    logic                data_mem_read;
    logic                data_mem_write;
  } rv32i_ctrl_packet_t;

  localparam rv32i_ctrl_packet_t BUBBLE_CTRL = '0;

  typedef struct packed {
    logic [XLEN-1:0] i;
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] u;
    logic [XLEN-1:0] j;
  } rv32i_imm_t;

  // All sign-extended RV32I immediate formats for one instruction word.
  function automatic rv32i_imm_t build_imm(input logic [XLEN-1:0] in);
    rv32i_imm_t r;
    r.i = {{21{in[31]}}, in[30:20]};
    r.s = {{21{in[31]}}, in[30:25], in[11:7]};
    r.b = {{20{in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
    r.u = {in[31:12], 12'h000};
    r.j = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
    return r;
  endfunction

endpackage

// File: rtl/control_rom.sv
// Control ROM: maps opcode/funct3/funct7 to the control packet.
// Ports: opcode, funct3, funct7 in; ctrl_c combinational packet out.
// Unknown opcodes decode to the all-zero packet.
module control_rom
  import id_ex_stage_pkg::*;
(
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  output rv32i_ctrl_packet_t ctrl_c
);

  logic alt_c;
  assign alt_c = (funct7 == 7'b0100000);

  always_comb begin
    ctrl_c        = BUBBLE_CTRL;
    ctrl_c.opcode = opcode;
    case (opcode)
      op_lui: begin
        ctrl_c.load_regfile = 1'b1;
        ctrl_c.alu_m2_sel   = 1'b1;
      end
      op_auipc: begin
        ctrl_c.load_regfile = 1'b1;
        ctrl_c.alu_m1_sel   = 1'b1;
        ctrl_c.alu_m2_sel   = 1'b1;
      end
      op_jal: begin
        ctrl_c.load_regfile = 1'b1;
        ctrl_c.jump         = 1'b1;
        ctrl_c.alu_m1_sel   = 1'b1;
        ctrl_c.alu_m2_sel   = 1'b1;
      end
      op_jalr: begin
        ctrl_c.load_regfile = 1'b1;
        ctrl_c.jump         = 1'b1;
        ctrl_c.alu_m2_sel   = 1'b1;
      end
      op_br: begin
        ctrl_c.branch     = 1'b1;
        ctrl_c.cmpop      = funct3;
        ctrl_c.alu_m1_sel = 1'b1;
        ctrl_c.alu_m2_sel = 1'b1;
      end
      op_load: begin
        ctrl_c.load_regfile  = 1'b1;
        ctrl_c.data_mem_read = 1'b1;
        ctrl_c.alu_m2_sel    = 1'b1;
      end
      op_store: begin
        ctrl_c.data_mem_write = 1'b1;
        ctrl_c.alu_m2_sel     = 1'b1;
      end
      op_imm: begin
        ctrl_c.load_regfile = 1'b1;
        ctrl_c.alu_m2_sel   = 1'b1;
        // Only SRAI uses the alternate funct7 among immediate ops.
        ctrl_c.aluop        = {alt_c && (funct3 == 3'b101), funct3};
      end
      op_reg: begin
        ctrl_c.load_regfile = 1'b1;
        ctrl_c.aluop        = {alt_c, funct3};
      end
      default: ctrl_c = BUBBLE_CTRL;
    endcase
  end

endmodule

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently sitting in ID/EX.
// Ports: id_valid, opcode, rs1, rs2 (ID side); ex_valid, ex_mem_read, ex_rd
// (ID/EX side); hz_c combinational hazard out.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid,
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hz_c
);

  logic uses_rs1_c;
  logic uses_rs2_c;

  always_comb begin
    uses_rs1_c = !((opcode == op_lui) || (opcode == op_auipc) || (opcode == op_jal));
    uses_rs2_c = (opcode == op_br) || (opcode == op_store) || (opcode == op_reg);
    hz_c = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
           ((uses_rs1_c && (rs1 == ex_rd)) || (uses_rs2_c && (rs2 == ex_rd)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode back half and ID/EX pipeline register.
// Ports: clk/rst (sync, active-high); IF/ID instruction and regfile read data
// in; WB write port for bypass; ex_stall/flush control in; id_stall comb out;
// registered ID/EX payload out; saturating bubble/stall performance counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [31:0]           id_pc,
  input  logic [31:0]           id_instr,
  input  logic [31:0]           rs1_out,
  input  logic [31:0]           rs2_out,
  input  logic                  wb_load_regfile,
  input  logic [4:0]            wb_rd,
  input  logic [31:0]           wb_data,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  id_stall,
  output logic                  ex_valid,
  output rv32i_ctrl_packet_t    ex_ctrl,
  output logic [31:0]           ex_pc,
  output logic [31:0]           ex_rs1_data,
  output logic [31:0]           ex_rs2_data,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic [2:0]            ex_funct3,
  output rv32i_imm_t            ex_imm,
  output logic [PERF_CNT_W-1:0] bubble_cnt,
  output logic [PERF_CNT_W-1:0] stall_cnt
);

  logic [4:0]         rs1_c, rs2_c, rd_c;
  logic [6:0]         dec_opcode_c, dec_funct7_c;
  logic [2:0]         dec_funct3_c;
  logic [31:0]        rs1_fwd_c, rs2_fwd_c;
  rv32i_ctrl_packet_t ctrl_c;
  logic               hz_c;

  assign rs1_c = id_instr[19:15];
  assign rs2_c = id_instr[24:20];
  assign rd_c  = id_instr[11:7];

  // An empty IF/ID slot decodes as a NOP so the ROM only ever sees legal input.
  assign dec_opcode_c = id_valid ? id_instr[6:0]   : NOP_INSTR[6:0];
  assign dec_funct3_c = id_valid ? id_instr[14:12] : 3'b000;
  assign dec_funct7_c = id_valid ? id_instr[31:25] : 7'b0000000;

  // WB write-through so a same-cycle regfile write is not missed; x0 never bypassed.
  assign rs1_fwd_c = (wb_load_regfile && (wb_rd != 5'd0) && (wb_rd == rs1_c)) ? wb_data : rs1_out;
  assign rs2_fwd_c = (wb_load_regfile && (wb_rd != 5'd0) && (wb_rd == rs2_c)) ? wb_data : rs2_out;

  control_rom u_control_rom (
    .opcode (dec_opcode_c),
    .funct3 (dec_funct3_c),
    .funct7 (dec_funct7_c),
    .ctrl_c (ctrl_c)
  );

  load_use_detect u_load_use_detect (
    .id_valid    (id_valid),
    .opcode      (id_instr[6:0]),
    .rs1         (rs1_c),
    .rs2         (rs2_c),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.data_mem_read),
    .ex_rd       (ex_rd),
    .hz_c        (hz_c)
  );

  // Flush outranks the hazard: the dependent instruction is being killed anyway.
  assign id_stall = !rst && (ex_stall || (!flush && hz_c));

  // ID/EX register with stall > flush > hazard > advance priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= BUBBLE_CTRL;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_imm      <= '0;
      bubble_cnt  <= '0;
      stall_cnt   <= '0;
    end else if (ex_stall) begin
      if (!(&stall_cnt)) stall_cnt <= stall_cnt + PERF_CNT_W'(1);
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= BUBBLE_CTRL;
    end else if (hz_c) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= BUBBLE_CTRL;
      if (!(&bubble_cnt)) bubble_cnt <= bubble_cnt + PERF_CNT_W'(1);
    end else begin
      ex_valid    <= id_valid;
      // An empty slot leaves EX with a true bubble rather than a live NOP packet.
      ex_ctrl     <= id_valid ? ctrl_c : BUBBLE_CTRL;
      ex_pc       <= id_pc;
      ex_rs1_data <= rs1_fwd_c;
      ex_rs2_data <= rs2_fwd_c;
      ex_rs1      <= rs1_c;
      ex_rs2      <= rs2_c;
      ex_rd       <= rd_c;
      ex_funct3   <= id_instr[14:12];
      ex_imm      <= build_imm(id_instr);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by randomized traffic,
// all checked against a cycle-level reference model of the ID/EX register.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int unsigned CW      = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic               clk;
  logic               rst;
  logic               id_valid;
  logic [31:0]        id_pc, id_instr, rs1_out, rs2_out;
  logic               wb_load_regfile;
  logic [4:0]         wb_rd;
  logic [31:0]        wb_data;
  logic               ex_stall, flush;
  logic               id_stall, ex_valid;
  rv32i_ctrl_packet_t ex_ctrl;
  logic [31:0]        ex_pc, ex_rs1_data, ex_rs2_data;
  logic [4:0]         ex_rs1, ex_rs2, ex_rd;
  logic [2:0]         ex_funct3;
  rv32i_imm_t         ex_imm;
  logic [CW-1:0]      bubble_cnt, stall_cnt;

  id_ex_stage #(.PERF_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .wb_load_regfile(wb_load_regfile),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_imm(ex_imm),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit          m_valid, m_lr, m_mr, m_mw;
  bit          m_ctrl_care, m_ctrl_zero, m_data_care;
  logic [31:0] m_pc, m_rs1d, m_rs2d;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [2:0]  m_f3;
  logic [31:0] m_imm [5];
  int unsigned m_bub, m_stl;
  bit          exp_stall;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bypass(input logic [4:0] idx, input logic [31:0] rf);
    if (wb_load_regfile && wb_rd != 5'd0 && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  // Reference immediates via arithmetic sign extension.
  task automatic ref_imm(input logic [31:0] in);
    logic [12:0] bt;
    logic [20:0] jt;
    m_imm[0] = 32'($signed(in) >>> 20);
    m_imm[1] = {m_imm[0][31:5], in[11:7]};
    bt = {in[31], in[7], in[30:25], in[11:8], 1'b0};
    m_imm[2] = 32'($signed(bt));
    m_imm[3] = in & 32'hFFFF_F000;
    jt = {in[31], in[19:12], in[20], in[30:21], 1'b0};
    m_imm[4] = 32'($signed(jt));
  endtask

  task automatic check_outputs();
    check_val("ex_valid", 32'(ex_valid), 32'(m_valid));
    check_val("bubble_cnt", 32'(bubble_cnt), m_bub);
    check_val("stall_cnt", 32'(stall_cnt), m_stl);
    if (m_ctrl_zero) check_val("ex_ctrl_zero", 32'(ex_ctrl), 32'd0);
    if (m_ctrl_care) begin
      check_val("load_regfile", 32'(ex_ctrl.load_regfile), 32'(m_lr));
      check_val("data_mem_read", 32'(ex_ctrl.data_mem_read), 32'(m_mr));
      check_val("data_mem_write", 32'(ex_ctrl.data_mem_write), 32'(m_mw));
    end
    if (m_data_care) begin
      check_val("ex_pc", ex_pc, m_pc);
      check_val("ex_rs1_data", ex_rs1_data, m_rs1d);
      check_val("ex_rs2_data", ex_rs2_data, m_rs2d);
      check_val("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
      check_val("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
      check_val("ex_rd", 32'(ex_rd), 32'(m_rd));
      check_val("ex_funct3", 32'(ex_funct3), 32'(m_f3));
      check_val("imm_i", ex_imm.i, m_imm[0]);
      check_val("imm_s", ex_imm.s, m_imm[1]);
      check_val("imm_b", ex_imm.b, m_imm[2]);
      check_val("imm_u", ex_imm.u, m_imm[3]);
      check_val("imm_j", ex_imm.j, m_imm[4]);
    end
  endtask

  // One clock: check id_stall on current inputs, advance the model, check registers.
  task automatic cycle();
    logic [6:0] op;
    bit u1, u2, hz;
    #1;
    op = id_instr[6:0];
    u1 = !(op == op_lui || op == op_auipc || op == op_jal);
    u2 = (op == op_br || op == op_store || op == op_reg);
    hz = id_valid && m_valid && m_mr && (m_rd != 5'd0) &&
         ((u1 && id_instr[19:15] == m_rd) || (u2 && id_instr[24:20] == m_rd));
    exp_stall = !rst && (ex_stall || (!flush && hz));
    check_val("id_stall", 32'(id_stall), 32'(exp_stall));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_lr = 0; m_mr = 0; m_mw = 0;
      m_ctrl_care = 0; m_ctrl_zero = 1; m_data_care = 1;
      m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0;
      for (int k = 0; k < 5; k++) m_imm[k] = 0;
      m_bub = 0; m_stl = 0;
    end else if (ex_stall) begin
      if (m_stl < CNT_MAX) m_stl++;
    end else if (flush || hz) begin
      m_valid = 0; m_lr = 0; m_mr = 0; m_mw = 0;
      m_ctrl_care = 0; m_ctrl_zero = 1; m_data_care = 0;
      if (!flush && m_bub < CNT_MAX) m_bub++;
    end else begin
      m_valid     = id_valid;
      m_ctrl_care = id_valid;
      m_ctrl_zero = 0;
      m_data_care = 1;
      m_lr = id_valid && (op inside {op_lui, op_auipc, op_jal, op_jalr, op_load, op_imm, op_reg});
      m_mr = id_valid && (op == op_load);
      m_mw = id_valid && (op == op_store);
      m_pc   = id_pc;
      m_rs1  = id_instr[19:15];
      m_rs2  = id_instr[24:20];
      m_rd   = id_instr[11:7];
      m_f3   = id_instr[14:12];
      m_rs1d = bypass(id_instr[19:15], rs1_out);
      m_rs2d = bypass(id_instr[24:20], rs2_out);
      ref_imm(id_instr);
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; id_valid = 0; id_pc = 0; id_instr = NOP_INSTR;
    rs1_out = 0; rs2_out = 0; wb_load_regfile = 0; wb_rd = 0; wb_data = 0;
    ex_stall = 0; flush = 0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    id_valid = 1; id_instr = instr; id_pc = pc;
    rs1_out = $urandom; rs2_out = $urandom;
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0;
  endtask

  localparam logic [6:0] OPS [10] = '{op_lui, op_auipc, op_jal, op_jalr, op_br,
                                      op_load, op_load, op_store, op_imm, op_reg};

  initial begin
    @(negedge clk);
    idle_inputs();
    do_reset();

    // addi x1,x0,5
    issue(32'h0050_0093, 32'h100); cycle();
    check_val("t1_valid", 32'(ex_valid), 32'd1);
    check_val("t1_rd", 32'(ex_rd), 32'd1);
    check_val("t1_imm_i", ex_imm.i, 32'd5);
    check_val("t1_lr", 32'(ex_ctrl.load_regfile), 32'd1);

    // lw x2,0(x1) ; add x3,x2,x2 -> one bubble
    issue(32'h0000_A103, 32'h104); cycle();
    issue(32'h0021_01B3, 32'h108); cycle();
    check_val("t2_bubble_valid", 32'(ex_valid), 32'd0);
    cycle();
    check_val("t2_add_valid", 32'(ex_valid), 32'd1);
    check_val("t2_add_rd", 32'(ex_rd), 32'd3);
    check_val("t2_bubble_cnt", 32'(bubble_cnt), 32'd1);

    // lw x0 ; add x3,x0,x0 -> no hazard; lw x2 ; lui x2 -> no hazard
    issue(32'h0000_A003, 32'h10C); cycle();
    issue(32'h0000_01B3, 32'h110); cycle();
    issue(32'h0000_A103, 32'h114); cycle();
    issue(32'h0000_1137, 32'h118); cycle();
    check_val("t3_bubble_cnt", 32'(bubble_cnt), 32'd1);

    // WB bypass of rs1=x4, then wb_rd=0 with rs1=x0
    issue(32'h0002_0293, 32'h11C);
    rs1_out = 0; wb_load_regfile = 1; wb_rd = 5'd4; wb_data = 32'hDEAD_BEEF;
    cycle();
    check_val("t4_bypass", ex_rs1_data, 32'hDEAD_BEEF);
    issue(32'h0000_0293, 32'h120);
    rs1_out = 32'h1234_5678; wb_rd = 5'd0; cycle();
    check_val("t4_x0", ex_rs1_data, 32'h1234_5678);
    wb_load_regfile = 0;

    // stall+flush for 3 cycles holds the branch, then flush alone kills it
    do_reset();
    issue(32'h0000_0063, 32'h200); cycle();
    ex_stall = 1; flush = 1;
    repeat (3) cycle();
    check_val("t5_stall_cnt", 32'(stall_cnt), 32'd3);
    check_val("t5_held_pc", ex_pc, 32'h200);
    ex_stall = 0; cycle();
    check_val("t5_flushed", 32'(ex_valid), 32'd0);
    flush = 0;

    // reset during a load-use stall, then saturate the stall counter
    issue(32'h0000_A103, 32'h300); cycle();
    issue(32'h0021_01B3, 32'h304); rst = 1; cycle(); rst = 0;
    check_val("t6_rst_valid", 32'(ex_valid), 32'd0);
    ex_stall = 1;
    repeat (CNT_MAX + 3) cycle();
    check_val("t6_sat", 32'(stall_cnt), CNT_MAX);
    ex_stall = 0;

    // randomized traffic; IF/ID is held whenever the stage requests a stall
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!exp_stall) begin
        logic [31:0] ins;
        ins = $urandom;
        ins[6:0]   = OPS[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        id_instr = ins;
        id_pc    = $urandom;
        id_valid = ($urandom_range(0, 99) < 85);
      end
      rs1_out         = $urandom;
      rs2_out         = $urandom;
      wb_load_regfile = $urandom_range(0, 1) == 1;
      wb_rd           = 5'($urandom_range(0, 3));
      wb_data         = $urandom;
      ex_stall        = ($urandom_range(0, 99) < 12);
      flush           = ($urandom_range(0, 99) < 10);
      rst             = ($urandom_range(0, 99) < 2);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
